// File: rtl/bram_11_rn.sv
// Single-port 11 x 32 synchronous RAM with byte-lane writes, read-first, registered output.
// Optional build macro BRAM11_RESET_CLEAR_EN: reset also clears every memory word.
module bram_11_rn (
    input  logic        CLK,
    input  logic        Resetn,
    input  logic        EN,
    input  logic [3:0]  WE,
    input  logic [11:0] A,
    input  logic [31:0] Di,
    output logic [31:0] Do
);

    localparam int DEPTH = 11;

    logic [31:0] mem [DEPTH];
    logic [9:0]  idx;
    logic        in_range;
    logic        wr_en;
    logic [31:0] rd_word;
    logic        unused_addr_bits;

    assign idx              = A[11:2];
    assign in_range         = (idx < 10'(DEPTH));
    assign wr_en            = EN && in_range && (WE != 4'h0);
    assign unused_addr_bits = ^A[1:0];

    // Out-of-range indices read as zero; the decode never aliases onto a valid word.
    always_comb begin
        rd_word = 32'h0;
        for (int w = 0; w < DEPTH; w++) begin
            if (idx == 10'(w)) begin
                rd_word = mem[w];
            end
        end
    end

`ifdef BRAM11_RESET_CLEAR_EN
    always_ff @(posedge CLK) begin
        if (!Resetn) begin
            for (int w = 0; w < DEPTH; w++) begin
                mem[w] <= 32'h0;
            end
        end else if (wr_en) begin
            for (int w = 0; w < DEPTH; w++) begin
                if (idx == 10'(w)) begin
                    for (int b = 0; b < 4; b++) begin
                        if (WE[b]) begin
                            mem[w][8*b +: 8] <= Di[8*b +: 8];
                        end
                    end
                end
            end
        end
    end
`else
    // Contents survive reset; only the write on a reset edge is suppressed.
    always_ff @(posedge CLK) begin
        if (Resetn && wr_en) begin
            for (int w = 0; w < DEPTH; w++) begin
                if (idx == 10'(w)) begin
                    for (int b = 0; b < 4; b++) begin
                        if (WE[b]) begin
                            mem[w][8*b +: 8] <= Di[8*b +: 8];
                        end
                    end
                end
            end
        end
    end
`endif

    // rd_word samples pre-edge contents, giving read-first behaviour on a same-word write.
    always_ff @(posedge CLK) begin
        if (!Resetn) begin
            Do <= 32'h0;
        end else if (EN) begin
            Do <= rd_word;
        end
    end

endmodule

// File: tb/tb_bram_11_rn.sv
// Directed bench for bram_11_rn: reset, writes/reads, byte lanes, range, read-first, enable.
module tb_bram_11_rn;

    logic        CLK;
    logic        Resetn;
    logic        EN;
    logic [3:0]  WE;
    logic [11:0] A;
    logic [31:0] Di;
    logic [31:0] Do;

    int n_cmp;
    int n_fail;

    bram_11_rn dut (
        .CLK    (CLK),
        .Resetn (Resetn),
        .EN     (EN),
        .WE     (WE),
        .A      (A),
        .Di     (Di),
        .Do     (Do)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic cycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        EN = 1'b0;
        WE = 4'h0;
    endtask

    task automatic do_write(input logic [11:0] addr, input logic [31:0] data, input logic [3:0] we);
        EN = 1'b1;
        WE = we;
        A  = addr;
        Di = data;
        cycle();
        idle();
    endtask

    task automatic do_read(input logic [11:0] addr);
        EN = 1'b1;
        WE = 4'h0;
        A  = addr;
        Di = 32'h0;
        cycle();
        idle();
    endtask

    task automatic test_reset();
        Resetn = 1'b0;
        EN = 1'b1;
        WE = 4'hF;
        A  = 12'h004;
        Di = 32'h000000FF;
        cycle();
        n_cmp++;
        if (Do !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_do: got %h expected %h", Do, 32'h0);
        end
        Resetn = 1'b1;
        do_read(12'h004);
        n_cmp++;
`ifdef BRAM11_RESET_CLEAR_EN
        if (Do !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_write_dropped: got %h expected %h", Do, 32'h0);
        end
`else
        if (Do === 32'h000000FF) begin
            n_fail++;
            $display("FAIL reset_write_dropped: got %h expected not %h", Do, 32'h000000FF);
        end
`endif
    endtask

    task automatic test_write_read();
        do_write(12'h004, 32'h000000FF, 4'hF);
        do_write(12'h008, 32'h0000FF00, 4'hF);
        // Back-to-back reads, each checked one cycle after its address.
        EN = 1'b1;
        WE = 4'h0;
        A  = 12'h004;
        cycle();
        n_cmp++;
        if (Do !== 32'h000000FF) begin
            n_fail++;
            $display("FAIL read_word1: got %h expected %h", Do, 32'h000000FF);
        end
        A = 12'h008;
        cycle();
        n_cmp++;
        if (Do !== 32'h0000FF00) begin
            n_fail++;
            $display("FAIL read_word2: got %h expected %h", Do, 32'h0000FF00);
        end
        idle();
    endtask

    task automatic test_byte_lanes();
        do_write(12'h004, 32'h000000F0, 4'hF);
        do_write(12'h004, 32'h0000000F, 4'hF);
        do_read(12'h004);
        n_cmp++;
        if (Do !== 32'h0000000F) begin
            n_fail++;
            $display("FAIL overwrite: got %h expected %h", Do, 32'h0000000F);
        end
        do_write(12'h004, 32'hAAAAAAAA, 4'b0010);
        do_read(12'h004);
        n_cmp++;
        if (Do !== 32'h0000AA0F) begin
            n_fail++;
            $display("FAIL lane1_write: got %h expected %h", Do, 32'h0000AA0F);
        end
        // Upper two lanes only, via the ignored low address bits.
        do_write(12'h007, 32'h5566BBCC, 4'b1100);
        do_read(12'h005);
        n_cmp++;
        if (Do !== 32'h5566AA0F) begin
            n_fail++;
            $display("FAIL lane32_write: got %h expected %h", Do, 32'h5566AA0F);
        end
        do_write(12'h004, 32'h0000AA0F, 4'hF);
    endtask

    task automatic test_out_of_range();
        logic [31:0] exp_word [11];
        for (int w = 0; w < 11; w++) begin
            exp_word[w] = 32'hC0DE0000 + 32'(w);
        end
        exp_word[1] = 32'h0000AA0F;
        exp_word[2] = 32'h0000FF00;
        for (int w = 0; w < 11; w++) begin
            if (w != 1 && w != 2) begin
                do_write(12'(w * 4), exp_word[w], 4'hF);
            end
        end
        do_write(12'h034, 32'h0000000D, 4'hF);
        do_write(12'h02C, 32'h0000000D, 4'hF);
        do_read(12'h000);
        do_read(12'h034);
        n_cmp++;
        if (Do !== 32'h0) begin
            n_fail++;
            $display("FAIL oor_read_idx13: got %h expected %h", Do, 32'h0);
        end
        do_read(12'h028);
        do_read(12'h02C);
        n_cmp++;
        if (Do !== 32'h0) begin
            n_fail++;
            $display("FAIL oor_read_idx11: got %h expected %h", Do, 32'h0);
        end
        for (int w = 0; w < 11; w++) begin
            do_read(12'(w * 4));
            n_cmp++;
            if (Do !== exp_word[w]) begin
                n_fail++;
                $display("FAIL oor_word%0d_intact: got %h expected %h", w, Do, exp_word[w]);
            end
        end
    endtask

    task automatic test_read_first();
        do_write(12'h004, 32'h0000000F, 4'hF);
        EN = 1'b1;
        WE = 4'hF;
        A  = 12'h004;
        Di = 32'h12345678;
        cycle();
        n_cmp++;
        if (Do !== 32'h0000000F) begin
            n_fail++;
            $display("FAIL read_first_old: got %h expected %h", Do, 32'h0000000F);
        end
        WE = 4'h0;
        cycle();
        idle();
        n_cmp++;
        if (Do !== 32'h12345678) begin
            n_fail++;
            $display("FAIL read_first_new: got %h expected %h", Do, 32'h12345678);
        end
    endtask

    task automatic test_enable_gating();
        EN = 1'b0;
        WE = 4'hF;
        A  = 12'h000;
        Di = 32'h00000001;
        cycle();
        cycle();
        n_cmp++;
        if (Do !== 32'h12345678) begin
            n_fail++;
            $display("FAIL en0_hold: got %h expected %h", Do, 32'h12345678);
        end
        idle();
        do_read(12'h000);
        n_cmp++;
        if (Do !== 32'hC0DE0000) begin
            n_fail++;
            $display("FAIL en0_no_write: got %h expected %h", Do, 32'hC0DE0000);
        end
    endtask

    task automatic test_reset_mid_op();
        do_read(12'h004);
        Resetn = 1'b0;
        EN = 1'b1;
        WE = 4'hF;
        A  = 12'h008;
        Di = 32'hDEADBEEF;
        cycle();
        n_cmp++;
        if (Do !== 32'h0) begin
            n_fail++;
            $display("FAIL midop_reset_do: got %h expected %h", Do, 32'h0);
        end
        Resetn = 1'b1;
        do_read(12'h008);
        n_cmp++;
`ifdef BRAM11_RESET_CLEAR_EN
        if (Do !== 32'h0) begin
            n_fail++;
            $display("FAIL midop_reset_mem: got %h expected %h", Do, 32'h0);
        end
`else
        if (Do !== 32'h0000FF00) begin
            n_fail++;
            $display("FAIL midop_reset_mem: got %h expected %h", Do, 32'h0000FF00);
        end
`endif
        do_write(12'h008, 32'h00C0FFEE, 4'hF);
        do_read(12'h008);
        n_cmp++;
        if (Do !== 32'h00C0FFEE) begin
            n_fail++;
            $display("FAIL post_reset_resume: got %h expected %h", Do, 32'h00C0FFEE);
        end
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        Resetn = 1'b0;
        EN     = 1'b0;
        WE     = 4'h0;
        A      = 12'h0;
        Di     = 32'h0;
        test_reset();
        test_write_read();
        test_byte_lanes();
        test_out_of_range();
        test_read_first();
        test_enable_gating();
        test_reset_mid_op();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
